// File: rtl/xadc_seq_pkg.sv
// Shared types and constants for the XADC sequencer stream transmitter.
// Channel defaults, the transmit FSM state encoding and the FIFO beat layout.
package xadc_seq_pkg;

    localparam logic [4:0] CH_V_DEF   = 5'h10;
    localparam logic [4:0] CH_I_DEF   = 5'h18;
    localparam int         DRP_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        PUSH = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [4:0]  tid;
        logic [15:0] tdata;
    } seq_beat_t;

    // True when a conversion belongs to one of the two channels the estimator consumes.
    function automatic logic is_seq_channel(input logic [4:0] ch,
                                            input logic [4:0] ch_v,
                                            input logic [4:0] ch_i);
        return (ch == ch_v) || (ch == ch_i);
    endfunction

endpackage

// File: rtl/xadc_seq_fifo.sv
// Synchronous FIFO of seq_beat_t samples feeding the AXI-Stream output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module xadc_seq_fifo
    import xadc_seq_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          push,
    input  seq_beat_t     wr_beat,
    input  logic          pop,
    output seq_beat_t     rd_beat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          push_ok
);

    seq_beat_t         mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push_ok) mem[wr_ptr] <= wr_beat;
    end

    // Empty FIFO presents zeros so the stream outputs are clean after reset.
    assign rd_beat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/xadc_seq_stream_tx.sv
// XADC end-of-conversion -> DRP read -> FIFO -> AXI-Stream transmitter (ap_clk domain).
// Define XADC_SEQ_TX_DROP_CNT_EN to implement drop_count; otherwise it reads 0.
module xadc_seq_stream_tx
    import xadc_seq_pkg::*;
#(
    parameter  int         FIFO_DEPTH  = 4,
    parameter  logic [4:0] CH_V        = CH_V_DEF,
    parameter  logic [4:0] CH_I        = CH_I_DEF,
    parameter  int         DRP_TIMEOUT = 15,
    localparam int         LW          = $clog2(FIFO_DEPTH) + 1,
    localparam int         TW          = $clog2(DRP_TIMEOUT + 1)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  enable,
    input  logic                  xadc_eoc,
    input  logic [4:0]            xadc_channel,
    output logic                  drp_den,
    output logic [DRP_ADDR_W-1:0] drp_daddr,
    output logic                  drp_dwe,
    input  logic [15:0]           drp_do,
    input  logic                  drp_drdy,
    output logic [15:0]           seq_out_tdata,
    output logic [4:0]            seq_out_tid,
    output logic                  seq_out_tvalid,
    input  logic                  seq_out_tready,
    output logic [LW-1:0]         fifo_level,
    output logic                  drp_timeout_err,
    output logic [15:0]           drop_count,
    output tx_state_t             dbg_state
);

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [4:0]    cur_ch;
    logic [4:0]    pend_ch;
    logic          pend_vld;
    logic [15:0]   cap_data;
    logic [TW-1:0] timer;

    logic          eoc_ok;
    logic          serve_pend;
    logic          start_new;
    logic          capture;
    logic          set_err;
    logic          eoc_to_pend;
    logic          pend_busy;
    logic          drop_pend;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_push_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    seq_beat_t     head_beat;

    assign eoc_ok = xadc_eoc & enable & is_seq_channel(xadc_channel, CH_V, CH_I);

    always_comb begin
        state_nxt  = state;
        serve_pend = 1'b0;
        start_new  = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                // The older pending event wins over a fresh EOC in the same cycle.
                if (pend_vld) begin
                    state_nxt  = REQ;
                    serve_pend = 1'b1;
                end else if (eoc_ok) begin
                    state_nxt = REQ;
                    start_new = 1'b1;
                end
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                if (drp_drdy) begin
                    capture   = 1'b1;
                    state_nxt = PUSH;
                end else if (timer == TW'(DRP_TIMEOUT)) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PUSH:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An accepted EOC not started directly goes to the one-deep pending slot.
    assign eoc_to_pend = eoc_ok & ~start_new;
    assign pend_busy   = pend_vld & ~serve_pend;
    assign drop_pend   = eoc_to_pend & pend_busy;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state           <= IDLE;
            cur_ch          <= '0;
            pend_vld        <= 1'b0;
            pend_ch         <= '0;
            cap_data        <= '0;
            timer           <= '0;
            drp_timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (serve_pend)     cur_ch <= pend_ch;
            else if (start_new) cur_ch <= xadc_channel;
            if (eoc_to_pend && !pend_busy) begin
                pend_vld <= 1'b1;
                pend_ch  <= xadc_channel;
            end else if (serve_pend) begin
                pend_vld <= 1'b0;
            end
            if (capture) cap_data <= drp_do;
            timer <= (state == WAIT) ? timer + 1'b1 : '0;
            if (set_err) drp_timeout_err <= 1'b1;
        end
    end

    assign drp_den   = (state == REQ);
    assign drp_daddr = {2'b00, cur_ch};
    assign drp_dwe   = 1'b0;
    assign dbg_state = state;

    // AXI-S: tvalid is level != 0; a beat transfers on tvalid & tready and the
    // head entry holds tdata/tid steady until that handshake.
    assign fifo_push = (state == PUSH);
    assign fifo_pop  = seq_out_tvalid & seq_out_tready;
    assign fifo_drop = fifo_push & ~fifo_push_ok;

    xadc_seq_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .push     (fifo_push),
        .wr_beat  ({cur_ch, cap_data}),
        .pop      (fifo_pop),
        .rd_beat  (head_beat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .push_ok  (fifo_push_ok)
    );

    assign seq_out_tvalid = ~fifo_empty;
    assign seq_out_tdata  = head_beat.tdata;
    assign seq_out_tid    = head_beat.tid;

`ifdef XADC_SEQ_TX_DROP_CNT_EN
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;
    logic        unused_full;

    assign unused_full = fifo_full;
    assign drop_inc    = {1'b0, drop_pend} + {1'b0, fifo_drop};
    assign drop_sum    = {1'b0, drop_count} + 17'(drop_inc);

    // Pending-slot and FIFO drops can coincide, so the step can be two.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) drop_count <= '0;
        else           drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`else
    logic unused_drop;

    assign unused_drop = drop_pend | fifo_drop | fifo_full;
    assign drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_xadc_seq_stream_tx.sv
// Self-checking bench for xadc_seq_stream_tx: DRP responder, AXI-S scoreboard and
// a transaction-level model of which samples reach the stream and which are dropped.
module tb_xadc_seq_stream_tx;
    import xadc_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [4:0]  ch;
        logic [15:0] data;
        int          lat;
    } drp_rsp_t;

    logic                  ap_clk = 1'b0;
    logic                  ap_rst_n;
    logic                  enable;
    logic                  xadc_eoc;
    logic [4:0]            xadc_channel;
    logic                  drp_den;
    logic [DRP_ADDR_W-1:0] drp_daddr;
    logic                  drp_dwe;
    logic [15:0]           drp_do;
    logic                  drp_drdy;
    logic [15:0]           seq_out_tdata;
    logic [4:0]            seq_out_tid;
    logic                  seq_out_tvalid;
    logic                  seq_out_tready;
    logic [LW-1:0]         fifo_level;
    logic                  drp_timeout_err;
    logic [15:0]           drop_count;
    tx_state_t             dbg_state;

    logic [20:0] exp_q[$];
    drp_rsp_t    drp_q[$];
    int          errors      = 0;
    int          checks      = 0;
    int          model_drops = 0;
    int          den_count   = 0;
    int          beats       = 0;
    int          lvl_hi_cnt  = 0;
    int          accepted    = 0;
    bit          drp_abort   = 1'b0;

    always #5 ap_clk = ~ap_clk;

    xadc_seq_stream_tx #(
        .FIFO_DEPTH  (DEPTH),
        .CH_V        (5'h10),
        .CH_I        (5'h18),
        .DRP_TIMEOUT (15)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .enable          (enable),
        .xadc_eoc        (xadc_eoc),
        .xadc_channel    (xadc_channel),
        .drp_den         (drp_den),
        .drp_daddr       (drp_daddr),
        .drp_dwe         (drp_dwe),
        .drp_do          (drp_do),
        .drp_drdy        (drp_drdy),
        .seq_out_tdata   (seq_out_tdata),
        .seq_out_tid     (seq_out_tid),
        .seq_out_tvalid  (seq_out_tvalid),
        .seq_out_tready  (seq_out_tready),
        .fifo_level      (fifo_level),
        .drp_timeout_err (drp_timeout_err),
        .drop_count      (drop_count),
        .dbg_state       (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_drop();
`ifdef XADC_SEQ_TX_DROP_CNT_EN
        return 16'(model_drops);
`else
        return 16'd0;
`endif
    endfunction

    // Main-process inputs change 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic drive_eoc(input bit en, input logic [4:0] ch);
        enable       = en;
        xadc_channel = ch;
        xadc_eoc     = 1'b1;
        tick();
        xadc_eoc     = 1'b0;
    endtask

    // Model: a filtered EOC causes one DRP read; its sample reaches the stream
    // unless the DRP times out or the output buffer is full when it lands.
    task automatic issue(input bit en, input logic [4:0] ch, input logic [15:0] data, input int lat);
        if (en && (ch == 5'h10 || ch == 5'h18)) begin
            accepted++;
            drp_q.push_back('{ch, data, lat});
            if (lat >= 0) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({ch, data});
                else model_drops++;
            end
        end
        drive_eoc(en, ch);
    endtask

    function automatic logic [15:0] rand_sample();
        logic [11:0] r12;
        r12 = 12'($urandom_range(0, 4095));
        return {r12, 4'h0};
    endfunction

    // DRP responder: answers each den with drdy 'lat' cycles later, or never if lat < 0.
    initial begin : drp_responder
        drp_rsp_t cur;
        int       cnt;
        bit       busy;
        bit       prev_den;
        busy     = 1'b0;
        cnt      = 0;
        prev_den = 1'b0;
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        forever begin
            @(negedge ap_clk);
            drp_drdy = 1'b0;
            if (drp_abort || !ap_rst_n) begin
                busy = 1'b0;
            end else if (drp_den) begin
                den_count++;
                check("den_single_cycle", 32'(prev_den), 32'd0);
                if (drp_q.size() == 0) begin
                    check("den_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = drp_q.pop_front();
                    check("drp_daddr", 32'(drp_daddr), 32'({2'b00, cur.ch}));
                    busy = (cur.lat >= 0);
                    cnt  = cur.lat;
                end
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = cur.data;
                    busy     = 1'b0;
                end
            end
            prev_den = drp_den && ap_rst_n;
        end
    end

    // Scoreboard: whenever tvalid is high the head must equal the oldest expected beat.
    initial begin : monitor
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n) begin
                if (fifo_level > 1) lvl_hi_cnt++;
                if (seq_out_tvalid) begin
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("beat_head", 32'({seq_out_tid, seq_out_tdata}), 32'(exp_q[0]));
                        if (seq_out_tready) begin
                            void'(exp_q.pop_front());
                            beats++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int          den0;
        int          lvl0;
        int          acc0;
        int          beats0;
        logic [15:0] d;
        logic [4:0]  ch;
        bit          en;
        int          sel;

        ap_rst_n       = 1'b1;
        enable         = 1'b0;
        xadc_eoc       = 1'b0;
        xadc_channel   = 5'h0;
        seq_out_tready = 1'b0;
        #2 ap_rst_n = 1'b0;
        #10;
        check("rst_tvalid",  32'(seq_out_tvalid), 32'd0);
        check("rst_level",   32'(fifo_level), 32'd0);
        check("rst_den",     32'(drp_den), 32'd0);
        check("rst_daddr",   32'(drp_daddr), 32'd0);
        check("rst_tdata",   32'(seq_out_tdata), 32'd0);
        check("rst_tid",     32'(seq_out_tid), 32'd0);
        check("rst_err",     32'(drp_timeout_err), 32'd0);
        check("rst_drop",    32'(drop_count), 32'd0);
        check("rst_dwe",     32'(drp_dwe), 32'd0);
        check("rst_state",   32'(dbg_state), 32'(IDLE));
        tick();
        ap_rst_n = 1'b1;
        tick(2);

        // Single read: latency, address, den width, beat contents.
        den0 = den_count;
        drp_q.push_back('{5'h10, 16'h1230, 2});
        exp_q.push_back({5'h10, 16'h1230});
        drive_eoc(1'b1, 5'h10);
        check("t1_den_latency", 32'(drp_den), 32'd1);
        check("t1_daddr", 32'(drp_daddr), 32'h10);
        tick();
        check("t1_den_width", 32'(drp_den), 32'd0);
        tick(2);
        check("t1_tvalid_early", 32'(seq_out_tvalid), 32'd0);
        tick();
        check("t1_tvalid_lat", 32'(seq_out_tvalid), 32'd1);
        check("t1_level", 32'(fifo_level), 32'd1);
        seq_out_tready = 1'b1;
        tick(3);
        check("t1_drained", 32'(exp_q.size()), 32'd0);
        check("t1_den_count", 32'(den_count - den0), 32'd1);

        // Alternating channels then randomized channel/enable/latency, tready held high.
        lvl0 = lvl_hi_cnt;
        den0 = den_count;
        acc0 = accepted;
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, (k % 2 == 0) ? 5'h10 : 5'h18, 16'(16'h10 * (k + 1)), 2);
            tick(12);
        end
        for (int k = 0; k < 16; k++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0, 1:    ch = 5'h10;
                2:       ch = 5'h18;
                3:       ch = 5'h03;
                default: ch = 5'($urandom_range(0, 31));
            endcase
            en = ($urandom_range(0, 4) != 0);
            d  = rand_sample();
            issue(en, ch, d, $urandom_range(1, 5));
            tick(12);
        end
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_level_le1", 32'(lvl_hi_cnt - lvl0), 32'd0);
        check("t2_den_count", 32'(den_count - den0), 32'(accepted - acc0));
        check("t2_drop", 32'(drop_count), 32'(exp_drop()));

        // Filtered EOCs, then enable dropping while a read is in flight.
        den0 = den_count;
        issue(1'b1, 5'h03, 16'h0AB0, 2);
        tick(6);
        issue(1'b0, 5'h10, 16'h0CD0, 2);
        tick(12);
        check("t4_no_den", 32'(den_count - den0), 32'd0);
        check("t4_no_beat", 32'(seq_out_tvalid), 32'd0);
        check("t4_drop", 32'(drop_count), 32'(exp_drop()));
        beats0 = beats;
        issue(1'b1, 5'h18, rand_sample(), 3);
        enable = 1'b0;
        tick(12);
        enable = 1'b1;
        check("t4_en_fall_beat", 32'(beats - beats0), 32'd1);

        // Stalled stream: buffer fills, later samples are dropped, then drain in order.
        seq_out_tready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, (k % 2 == 0) ? 5'h18 : 5'h10, rand_sample(), $urandom_range(1, 4));
            tick(12);
        end
        check("t3_level_full", 32'(fifo_level), 32'd4);
        check("t3_model_level", 32'(exp_q.size()), 32'd4);
        check("t3_tvalid", 32'(seq_out_tvalid), 32'd1);
        check("t3_drop", 32'(drop_count), 32'(exp_drop()));
        tick(5);
        beats0 = beats;
        seq_out_tready = 1'b1;
        tick(8);
        check("t3_drain_beats", 32'(beats - beats0), 32'd4);
        check("t3_level_empty", 32'(fifo_level), 32'd0);

        // Two EOCs during a read: first waits in the pending slot, second is dropped;
        // the pending read then times out.
        den0 = den_count;
        d = rand_sample();
        drp_q.push_back('{5'h10, d, 6});
        exp_q.push_back({5'h10, d});
        drive_eoc(1'b1, 5'h10);
        drp_q.push_back('{5'h18, 16'h0, -1});
        drive_eoc(1'b1, 5'h18);
        model_drops++;
        drive_eoc(1'b1, 5'h10);
        check("t5_err_clear", 32'(drp_timeout_err), 32'd0);
        tick(40);
        check("t5_timeout_err", 32'(drp_timeout_err), 32'd1);
        check("t5_state_idle", 32'(dbg_state), 32'(IDLE));
        check("t5_drop", 32'(drop_count), 32'(exp_drop()));
        check("t5_beats", 32'(exp_q.size()), 32'd0);
        check("t5_den_count", 32'(den_count - den0), 32'd2);

        // Reset in the middle of a read with three samples buffered.
        seq_out_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 5'h10, rand_sample(), 2);
            tick(12);
        end
        check("t6_level3", 32'(fifo_level), 32'd3);
        drp_q.push_back('{5'h18, 16'h0, -1});
        drive_eoc(1'b1, 5'h18);
        tick(3);
        check("t6_in_wait", 32'(dbg_state), 32'(WAIT));
        check("t6_err_sticky", 32'(drp_timeout_err), 32'd1);
        ap_rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", 32'(seq_out_tvalid), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_err", 32'(drp_timeout_err), 32'd0);
        check("t6_rst_drop", 32'(drop_count), 32'd0);
        check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
        drp_q.delete();
        model_drops = 0;
        drp_abort   = 1'b1;
        tick(2);
        ap_rst_n = 1'b1;
        tick();
        drp_abort = 1'b0;
        seq_out_tready = 1'b1;
        beats0 = beats;
        issue(1'b1, 5'h18, rand_sample(), 3);
        tick(12);
        check("t6_after_beat", 32'(beats - beats0), 32'd1);
        check("t6_after_empty", 32'(exp_q.size()), 32'd0);
        check("t6_after_err", 32'(drp_timeout_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xadc_seq_stream_tx.md
Name: xadc_seq_stream_tx

Overview:
- Transmit end of the XADC sequencer stream consumed by the parameter estimator (seq_in_xadc_* AXI-Stream slave port).
- On each XADC end-of-conversion, reads the conversion result over DRP, filters to the voltage/current channels, buffers it and emits one beat per sample: tdata = raw 16-bit result, tid = channel.
- Sits between the XADC primitive and the estimator IP, in the ap_clk domain.

Parameters:
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)
- CH_V, 5'h10, voltage channel id (VAUX0)
- CH_I, 5'h18, current channel id (VAUX8)
- DRP_TIMEOUT, 15, cycles to wait for drp_drdy before abandoning a read

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  reset; asynchronous assert, active-low
- enable  in  1  1 = accept EOC events; 0 = ignore new EOCs, FIFO still drains
- xadc_eoc  in  1  end-of-conversion pulse, one cycle
- xadc_channel  in  5  channel of the completed conversion, valid with xadc_eoc
- drp_den  out  1  DRP enable pulse
- drp_daddr  out  7  DRP address, {2'b00, channel}
- drp_dwe  out  1  constant 0
- drp_do  in  16  DRP read data
- drp_drdy  in  1  DRP read-data strobe
- seq_out_tdata  out  16  sample, raw XADC result, left-justified 12-bit
- seq_out_tid  out  5  channel id
- seq_out_tvalid  out  1  AXI-S valid
- seq_out_tready  in  1  AXI-S ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- drp_timeout_err  out  1  sticky; cleared only by reset
- drop_count  out  16  see Optional Feature

Behaviour:
- Reset (ap_rst_n=0, async): FSM IDLE; drp_den=0, drp_daddr=0, tvalid=0, tdata=0, tid=0, fifo_level=0, pending=0, drp_timeout_err=0, drop_count=0.
- EOC filter: an EOC is accepted only if enable=1 and xadc_channel is CH_V or CH_I. Other EOCs are ignored and not counted.
- FSM states and transitions:
  - IDLE: accepted EOC (or pending=1) -> REQ.
  - REQ: drp_den=1 for exactly one cycle, daddr latched -> WAIT.
  - WAIT: drp_drdy=1 -> capture drp_do, go to PUSH. Timer reaches DRP_TIMEOUT -> set drp_timeout_err, back to IDLE (sample lost, not counted as a drop).
  - PUSH: write {tid, tdata} into FIFO in one cycle -> IDLE.
- EOC arriving while FSM is not IDLE: latch into a one-deep pending slot (channel stored).
  - If pending is already full, the newer EOC is dropped and drop_count increments.
  - Pending is served on the IDLE->REQ transition and cleared there.
- Latency: EOC sampled at edge N, den high in cycle N+1. drdy sampled at edge K, FIFO write at edge K+1. With an empty FIFO, tvalid=1 after edge K+1.
- FIFO / AXI-S rules:
  - Head entry drives tdata/tid.
  - tvalid = (level != 0). Once asserted, tdata/tid stay stable until the tvalid&tready handshake.
  - Handshake pops one entry per cycle.
- FIFO boundary conditions:
  - PUSH with FIFO full and no pop in that cycle: sample dropped, drop_count++, FIFO unchanged.
  - PUSH with FIFO full and a simultaneous pop: push accepted, level unchanged.
  - Simultaneous push and pop on an empty FIFO: no bypass; the beat appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- drop_count saturates at 16'hFFFF.
- enable falling mid-read: the in-flight read completes and is pushed; the pending slot is still served.
- Reset mid-operation: all state cleared immediately, in-flight DRP read abandoned, FIFO emptied.

Optional Feature:
- Macro: XADC_SEQ_TX_DROP_CNT_EN.
- Defined: drop_count implemented as above.
- Undefined: counter logic removed; drop_count tied to 16'd0; dropping behaviour is otherwise identical.

Decomposition:
- Package xadc_seq_pkg:
  - CH_V/CH_I default constants, DRP_ADDR_W=7
  - state enum tx_state_t {IDLE, REQ, WAIT, PUSH}
  - struct seq_beat_t {logic [4:0] tid; logic [15:0] tdata;}
- Sub-module xadc_seq_fifo: synchronous FIFO of seq_beat_t, parameterised by FIFO_DEPTH, with push/pop/full/empty/level outputs and the simultaneous full push+pop rule above.

Test Plan:
- Reset, then xadc_eoc with channel 5'h10; DRP model returns 16'h1230 two cycles after den -> one beat tid=5'h10, tdata=16'h1230; drp_daddr=7'h10; den high exactly 1 cycle.
- Alternate EOCs ch 5'h10 / 5'h18, data 0x0010 and up incrementing by 0x10, tready=1 -> beats in identical order and values; fifo_level never exceeds 1.
- tready=0; 6 valid EOCs with FIFO_DEPTH=4 -> fifo_level=4; drop_count=2 with macro defined, 0 without. Raise tready -> first 4 samples out in order, tdata stable while stalled.
- EOC on ch 5'h03 and EOC with enable=0 -> no den, no beat, drop_count unchanged.
- Two extra EOCs during WAIT -> first is pending and served next, second dropped (drop_count=1); drdy withheld 16 cycles -> drp_timeout_err=1, FSM back to IDLE.
- Assert ap_rst_n=0 in WAIT with 3 entries queued -> tvalid=0, fifo_level=0 immediately; after release, a new EOC is processed normally.
